// File: rtl/restoring_divider_16x8.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake, with a single-cycle divide-by-zero shortcut.
module restoring_divider_16x8 #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      count;
  logic [DIVISOR_W-1:0]  rem_r;
  logic [DIVISOR_W-1:0]  dvsr_r;
  logic [DIVISOR_W-1:0]  rem_next;
  logic [DIVIDEND_W-1:0] q_r;
  logic [DIVIDEND_W-1:0] q_next;
  logic [DIVISOR_W:0]    shifted;
  logic                  fits;

  // The partial remainder's top bit is always zero after an update, so only
  // the low bits are stored; the shifted value is widened for the compare.
  always_comb begin
    shifted  = {rem_r, q_r[DIVIDEND_W-1]};
    fits     = (shifted >= {1'b0, dvsr_r});
    rem_next = fits ? (shifted[DIVISOR_W-1:0] - dvsr_r) : shifted[DIVISOR_W-1:0];
    q_next   = {q_r[DIVIDEND_W-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      rem_r       <= '0;
      dvsr_r      <= '0;
      q_r         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE accepts a new start exactly like IDLE for back-to-back use.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[DIVISOR_W-1:0];
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              dvsr_r <= divisor;
              q_r    <= dividend;
              rem_r  <= '0;
              count  <= '0;
              busy   <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          rem_r <= rem_next;
          q_r   <= q_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            quotient    <= q_next;
            remainder   <= rem_next;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider_16x8.sv
// Scoreboard bench for restoring_divider_16x8: stimulus pushes expected
// results from plain '/' and '%' arithmetic; a negedge monitor pops on done.
module tb_restoring_divider_16x8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          exp_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_slot;

  restoring_divider_16x8 dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic nextSlot();
    @(posedge clk);
    #2;
  endtask

  // Drive one start for a cycle and record what the divider must answer.
  task automatic applyStimulus(input logic [15:0] dd, input logic [7:0] dv);
    exp_t e;
    if (dv == 0) begin
      e.q  = 16'hFFFF;
      e.r  = dd[7:0];
      e.dz = 1'b1;
      e.exp_cyc = cyc + 1;
    end else begin
      e.q  = 16'(dd / dv);
      e.r  = 8'(dd % dv);
      e.dz = 1'b0;
      e.exp_cyc = cyc + 1 + 16;
    end
    done_slot = e.exp_cyc;
    sb.push_back(e);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    nextSlot();
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic pulseIgnored(input logic [15:0] dd, input logic [7:0] dv);
    start = 1'b1; dividend = dd; divisor = dv;
    nextSlot();
    start = 1'b0;
  endtask

  task automatic waitUntil(input int slot);
    for (int i = 0; i < 64 && cyc < slot; i++) nextSlot();
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && sb.size() != 0; i++) nextSlot();
    checkOutput("scoreboard_drained", sb.size(), 0);
  endtask

  // Monitor: compares each done against the oldest expectation, including when it arrived.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        checkOutput("busy_with_done", busy, 0);
        if (sb.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("quotient", quotient, e.q);
          checkOutput("remainder", remainder, e.r);
          checkOutput("div_by_zero", div_by_zero, e.dz);
          checkOutput("done_cycle", cyc, e.exp_cyc);
        end
      end else if (sb.size() != 0 && cyc > sb[0].exp_cyc) begin
        exp_t e;
        e = sb.pop_front();
        total++; bad++;
        $display("[TB] FAIL missing_done: got none by cycle %0d expected at %0d", cyc, e.exp_cyc);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int bcount;
    logic [15:0] dd;
    logic [7:0]  dv;

    // Reset values
    nextSlot(); nextSlot();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_quotient", quotient, 0);
    checkOutput("rst_remainder", remainder, 0);
    checkOutput("rst_dz", div_by_zero, 0);
    rst = 1'b0;
    nextSlot();

    // 1000/7 with busy duration
    applyStimulus(16'd1000, 8'd7);
    bcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) bcount++;
      nextSlot();
    end
    checkOutput("busy_cycles", bcount, 16);
    drain();

    applyStimulus(16'd65535, 8'd255);
    drain();
    applyStimulus(16'd5, 8'd9);
    drain();

    // Divide by zero: busy must never rise
    applyStimulus(16'd100, 8'd0);
    bcount = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy) bcount++;
      nextSlot();
    end
    checkOutput("dz_busy_cycles", bcount, 0);
    drain();

    // Starts during RUN ignored, then back-to-back start in DONE cycle
    applyStimulus(16'd1000, 8'd7);
    n = cyc;
    waitUntil(n + 2);
    pulseIgnored(16'd50, 8'd5);
    waitUntil(n + 8);
    pulseIgnored(16'd50, 8'd5);
    waitUntil(n + 16);
    applyStimulus(16'd50, 8'd5);
    drain();

    // Reset on the 8th RUN cycle aborts without a done
    applyStimulus(16'd1000, 8'd7);
    n = cyc;
    waitUntil(n + 7);
    rst = 1'b1;
    sb.delete();
    nextSlot();
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_quotient", quotient, 0);
    checkOutput("abort_remainder", remainder, 0);
    checkOutput("abort_dz", div_by_zero, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) nextSlot();
    applyStimulus(16'd200, 8'd3);
    drain();

    // Randomized back-to-back operations with edge operands mixed in
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 7))
        0: dv = 8'd1;
        1: dv = 8'd255;
        2: dv = 8'd0;
        default: dv = 8'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: dd = 16'd0;
        1: dd = 16'd65535;
        default: dd = 16'($urandom);
      endcase
      applyStimulus(dd, dv);
      waitUntil(done_slot);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
